// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous-read memory.
// Each grant runs IDLE/RESP -> ACCESS -> RESP; the owner is acked in RESP.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_prio;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wd;
    logic [DATA_W-1:0] r_rd0;
    logic [DATA_W-1:0] r_rd1;

    logic w_resp;
    logic w_req0;
    logic w_req1;
    logic w_grant;
    logic w_winner;

    assign w_resp = (r_state == RESP);

    // In RESP the current owner's request is ignored so the other port gets a turn.
    assign w_req0   = req0 & ~(w_resp & ~r_owner);
    assign w_req1   = req1 & ~(w_resp &  r_owner);
    assign w_grant  = (r_state != ACCESS) & (w_req0 | w_req1);
    assign w_winner = (w_req0 & w_req1) ? r_prio : w_req1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? ACCESS : IDLE;
            ACCESS:  w_next = RESP;
            RESP:    w_next = w_grant ? ACCESS : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wd    <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= w_winner;
                r_we    <= w_winner ? we1  : we0;
                r_adr   <= w_winner ? adr1 : adr0;
                r_wd    <= w_winner ? wd1  : wd0;
                r_prio  <= ~w_winner;
            end
            if (w_resp && !r_we) begin
                if (r_owner) r_rd1 <= mem_rd;
                else         r_rd0 <= mem_rd;
            end
        end
    end

    // Read data bypasses the holding register in RESP so it is valid with the ack.
    assign ack0    = w_resp & ~r_owner;
    assign ack1    = w_resp &  r_owner;
    assign rd0     = (w_resp && !r_owner && !r_we) ? mem_rd : r_rd0;
    assign rd1     = (w_resp &&  r_owner && !r_we) ? mem_rd : r_rd1;
    assign mem_we  = (r_state == ACCESS) & r_we;
    assign mem_adr = r_adr;
    assign mem_wd  = r_wd;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, ack scoreboard and
// hand-written sequences for arbitration, reset abort and latched-address cases.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] adr0, adr1;
    logic [7:0]  wd0, wd1;
    logic        ack0, ack1;
    logic [7:0]  rd0, rd1;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .ack0(ack0), .ack1(ack1), .rd0(rd0), .rd1(rd1),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_wd;
        mem_rd <= mem[mem_adr];
    end

    typedef struct {
        logic       port;
        logic [7:0] rd;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] adr;
        logic [7:0]  data;
    } vec_t;
    vec_t vecs[12];

    logic [7:0] mdl_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (ack0 || ack1)) begin
            chk("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
                chk("ack_rd", {24'd0, ack1 ? rd1 : rd0}, {24'd0, e.rd});
            end
        end
    end

    task automatic push_exp(input logic port, input logic we, input logic [7:0] data);
        exp_t e;
        if (!we) mdl_rd[port] = data;
        e.port = port;
        e.rd   = mdl_rd[port];
        sb.push_back(e);
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [15:0] adr, input logic [7:0] wd);
        if (port) begin req1 = req; we1 = we; adr1 = adr; wd1 = wd; end
        else      begin req0 = req; we0 = we; adr0 = adr; wd0 = wd; end
    endtask

    // One access from IDLE; returns at the negedge of the ack cycle with req dropped.
    task automatic do_access(input vec_t v);
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.adr, v.data);
        push_exp(v.port, v.we, v.data);
        @(negedge clk);
        chk("access_busy", {31'd0, busy}, 32'd1);
        chk("access_mem_we", {31'd0, mem_we}, {31'd0, v.we});
        chk("access_mem_adr", {16'd0, mem_adr}, {16'd0, v.adr});
        if (v.we) chk("access_mem_wd", {24'd0, mem_wd}, {24'd0, v.data});
        @(negedge clk);
        chk("ack_latency", {31'd0, v.port ? ack1 : ack0}, 32'd1);
        drive(v.port, 1'b0, v.we, v.adr, v.data);
    endtask

    task automatic wait_acks(input int n, input int first, input int spacing);
        int cyc = 0;
        int cnt = 0;
        int last = 0;
        while (cnt < n && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                if (cnt == 0) chk("first_ack_latency", cyc, first);
                else          chk("ack_spacing", cyc - last, spacing);
                last = cyc;
                cnt++;
            end
        end
        if (cnt < n) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", cnt, n);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h001C, 8'hB9};
        vecs[1]  = '{1'b1, 1'b0, 16'h001C, 8'hB9};
        vecs[2]  = '{1'b1, 1'b1, 16'h1234, 8'h5A};
        vecs[3]  = '{1'b0, 1'b0, 16'h1234, 8'h5A};
        vecs[4]  = '{1'b0, 1'b1, 16'hFFFF, 8'h3C};
        vecs[5]  = '{1'b1, 1'b0, 16'hFFFF, 8'h3C};
        vecs[6]  = '{1'b1, 1'b1, 16'h0000, 8'hA5};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 8'hA5};
        vecs[8]  = '{1'b0, 1'b1, 16'h0010, 8'h77};
        vecs[9]  = '{1'b1, 1'b1, 16'h0020, 8'h88};
        vecs[10] = '{1'b1, 1'b1, 16'h0040, 8'h11};
        vecs[11] = '{1'b0, 1'b0, 16'h0020, 8'h88};

        reset = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;

        #2;
        chk("reset_outputs", {ack0, ack1, mem_we, busy, mem_adr, mem_wd},
            {4'b0000, 16'h0000, 8'h00});
        chk("reset_rd", {16'd0, rd0, rd1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int unsigned i = 0; i < 12; i++) do_access(vecs[i]);

        // Address/we/wd change and req drop mid-ACCESS must not disturb the access.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        push_exp(1'b0, 1'b0, 8'h77);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 16'h0020, 8'hFF);
        #1;
        chk("latched_mem_adr", {16'd0, mem_adr}, 32'h0010);
        chk("latched_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("dropped_req_ack0", {31'd0, ack0}, 32'd1);
        we0 = 1'b0;

        // Single requester held: served from IDLE each time.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h00);
        for (int k = 0; k < 3; k++) push_exp(1'b1, 1'b0, 8'h3C);
        wait_acks(3, 2, 3);
        req1 = 1'b0;
        chk("rd0_held", {24'd0, rd0}, {24'd0, mdl_rd[0]});

        // Both ports held from reset: strict alternation starting with port 0.
        @(negedge clk);
        reset = 1'b0;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        drive(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, 1'b0, 8'h5A);
            push_exp(1'b1, 1'b0, 8'hA5);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_acks(4, 2, 2);
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset during the ACCESS of a write aborts it without ack or memory update.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0040, 8'hEE);
        @(negedge clk);
        chk("abort_mem_we_before", {31'd0, mem_we}, 32'd1);
        #2;
        reset = 1'b0;
        req0 = 1'b0;
        we0 = 1'b0;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_adr", {16'd0, mem_adr}, 32'd0);
        @(negedge clk);
        chk("abort_no_ack", {30'd0, ack0, ack1}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 16'h001C, 8'h00);
        push_exp(1'b0, 1'b0, 8'h11);
        push_exp(1'b1, 1'b0, 8'hB9);
        reset = 1'b1;
        wait_acks(2, 2, 2);
        req0 = 1'b0;
        req1 = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("idle_at_end", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
